// File: rtl/aes_pkg.sv
// AES shared constants and helpers.
// Key-schedule FSM states, rcon table, word-level S-box functions.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    EMIT = 2'd2
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'd14;
  localparam logic [3:0] FWD_CYCLES = 4'd13;

  localparam logic [7:0] RCON [8] = '{
    8'h00, 8'h01, 8'h02, 8'h04,
    8'h08, 8'h10, 8'h20, 8'h40
  };

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the field inverse (and maps 0 to 0)
  function automatic logic [7:0] sbox_byte(
    input logic [7:0] x
  );
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]}
             ^ 8'h63;
  endfunction

  function automatic logic [31:0] rot_word(
    input logic [31:0] x
  );
    return {x[23:0], x[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(
    input logic [31:0] x
  );
    return {sbox_byte(x[31:24]), sbox_byte(x[23:16]),
            sbox_byte(x[15:8]), sbox_byte(x[7:0])};
  endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// Four parallel AES byte S-boxes on one 32-bit word.
// Purely combinational; shared with the encrypt key path.
module aes_sbox_word
  import aes_pkg::*;
(
  input  logic [31:0] x,
  output logic [31:0] y
);

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign y[8*i +: 8] = sbox_byte(x[8*i +: 8]);
  end

endmodule

// File: rtl/aes256_dec_key_sched.sv
// AES-256 decryption key scheduler.
// Expands forward to rk13/rk14, then walks the schedule back to rk0.
module aes256_dec_key_sched
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk,
  output logic [3:0]   rk_round,
  output logic         rk_last
);

  state_t            state;
  logic [0:3][31:0]  a;
  logic [0:3][31:0]  b;
  logic [3:0]        k;

  logic              fwd;
  logic              hs;
  logic [31:0]       sin;
  logic [31:0]       sout;
  logic [3:0]        n;
  logic [31:0]       g;
  logic [0:3][31:0]  nw;
  logic [0:3][31:0]  pw;

  assign fwd = (state == FWD);
  assign hs  = rk_valid & rk_ready;

  // single S-box word: B[3] going forward, A[3] going backward
  assign sin = fwd ? b[3] : a[3];

  aes_sbox_word u_sbox (
    .x (sin),
    .y (sout)
  );

  // g() index: rk(k+1) forward, rk(k) when recovering rk(k-2)
  assign n = fwd ? k + 4'd1 : k;
  assign g = n[0] ? sout
                  : rot_word(sout) ^ {RCON[n[3:1]], 24'h0};

  // next forward key and previous backward key
  always_comb begin
    nw[0] = a[0] ^ g;
    pw[0] = b[0] ^ g;
    for (int j = 1; j < 4; j++) begin
      nw[j] = a[j] ^ nw[j-1];
      pw[j] = b[j] ^ b[j-1];
    end
  end

  // FSM, key window and round counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      k     <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a     <= key_in[255:128];
            b     <= key_in[127:0];
            k     <= 4'd1;
            state <= FWD;
          end
        end
        FWD: begin
          a <= b;
          b <= nw;
          k <= k + 4'd1;
          if (k == FWD_CYCLES) state <= EMIT;
        end
        EMIT: begin
          if (hs) begin
            if (k >= 4'd2) begin
              a <= pw;
              b <= a;
              k <= k - 4'd1;
            end else if (k == 4'd1) begin
              b <= a;
              k <= 4'd0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign rk_valid = (state == EMIT);
  assign rk       = rk_valid ? b : '0;
  assign rk_round = rk_valid ? k : 4'd0;
  assign rk_last  = rk_valid && (k == 4'd0);

endmodule

// File: doc/aes256_dec_key_sched.md
# aes256_dec_key_sched

Sequential AES-256 decryption key scheduler. It takes a 256-bit cipher key and runs the forward expansion in place to reach round keys 13/14. It then streams round keys 14 down to 0 over a valid/ready interface, stepping the schedule backwards, with no 15-entry key store. It sits beside the round-key generator used by the encrypt datapath and feeds the inverse-cipher rounds.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, one synchronous active-high reset
- start  in  1  load key_in and begin; sampled only in IDLE
- key_in  in  256  cipher key; [255:128] = rk0, [127:0] = rk1
- busy  out  1  high in any state other than IDLE
- rk_valid  out  1  rk is valid (EMIT only)
- rk_ready  in  1  consumer accepts rk this cycle
- rk  out  128  current round key, word 0 in [127:96]
- rk_round  out  4  index of rk (14..0)
- rk_last  out  1  high with rk_valid when rk_round == 0

## Operation
- State: window W = {A, B} (A = rk(k-1), B = rk(k)), counter k[3:0], FSM {IDLE, FWD, EMIT}.
- g(x, n):
  - n even: SubWord(RotWord(x)) ^ {rcon[n/2], 24'h0}.
  - n odd: SubWord(x).
  - rcon[1..7] = 01, 02, 04, 08, 10, 20, 40.
- There is one shared 4-byte S-box word.
  - In FWD its input is B word 3.
  - In EMIT its input is A word 3.
- IDLE:
  - start=1 loads W <= key_in and k <= 1, then goes to FWD.
  - start=0 holds.
- FWD:
  - Compute new = rk(k+1): new[0] = A[0] ^ g(B[3], k+1); new[j] = A[j] ^ new[j-1] for j = 1..3.
  - Update W <= {B, new} and k <= k+1.
  - When k+1 == 14, go to EMIT.
  - FWD lasts exactly 13 cycles.
- EMIT:
  - rk = B, rk_round = k, rk_valid = 1.
  - On a handshake (rk_valid & rk_ready) with k ≥ 2:
    - Compute P = rk(k-2): P[0] = B[0] ^ g(A[3], k); P[j] = B[j] ^ B[j-1].
    - Update W <= {P, A} and k <= k-1.
  - On a handshake with k == 1: W <= {A, A} (B becomes rk0), k <= 0.
  - On a handshake with k == 0: go to IDLE.
  - With no handshake, W, k and all outputs hold stable. rk must not change while rk_valid & !rk_ready.
- start in FWD/EMIT is ignored. No abort exists except reset.
- Reset, at any state including mid-FWD or mid-EMIT:
  - state IDLE, k = 0, W = 0.
  - busy, rk_valid, rk_last = 0; rk = 0, rk_round = 0.
- Arithmetic: all key math is GF(2) XOR; k never wraps (range 0..14).

## Timing
- start sampled at edge t: FWD during cycles t+1..t+13, rk_valid first high in cycle t+14 with rk_round = 14.
- With rk_ready held high: 15 consecutive keys, one per cycle, then IDLE at t+29.
- busy is high from t+1 through the cycle holding the rk_last handshake. A new start is accepted the following cycle.
- Outputs are registered or decoded directly from state/W. There is no combinational path from rk_ready to rk, only to the next state.
- Critical path: S-box + 2 XOR + 3-deep XOR chain (FWD). The EMIT path is shallower.

## Structure
- aes_pkg holds:
  - The rcon table.
  - The state enum (IDLE/FWD/EMIT).
  - The constants LAST_ROUND = 14 and FWD_CYCLES = 13.
  - The RotWord/SubWord helper functions.
- Sub-module: aes_sbox_word (4 parallel byte S-boxes, combinational), shared with the encrypt key path.
- FSM, window and counter stay in this module.

## Test plan
- FIPS-197 A.3 key 603deb10…0914dff4, rk_ready=1:
  - First key rk_round=14, rk=fe4890d1e6188d0b046df344706c631e.
  - rk_round=2 gives 9ba354118e6925afa51a8b5f2067fcde.
  - rk_round=1 gives 1f352c073b6108d72d9810a30914dff4.
  - Last key rk0=603deb1015ca71be2b73aef0857d7781 with rk_last=1.
  - rk_valid first rises exactly 14 cycles after start.
- Backpressure: rk_ready random 30% duty. Every rk matches the software model in order 14..0, and rk/rk_round stay stable while stalled.
- Reset mid-FWD (cycle t+5) and mid-EMIT (after 4 keys) -> next cycle all outputs 0, busy=0. A following start produces the correct full sequence.
- start pulsed during FWD and EMIT -> ignored, sequence unaffected. start held high continuously -> back-to-back runs with one IDLE cycle between.
- All-zero key and all-ones key -> output matches the reference model for all 15 round keys. Check that busy falls the cycle after the rk_last handshake.
